// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the load/store funct3 encodings, the responder state type and a
// helper that classifies funct3 values the responder cannot serve.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Unsigned loads have no store counterpart, and 011/110/111 are unused.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return is_store;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter for the data-memory responder (purely combinational).
// Ports:
//   addr_lo     - byte offset within the word (addr[1:0])
//   funct3      - access size/sign
//   old_word    - current contents of the addressed word
//   store_data  - store data, LSB-aligned for SB/SH
//   merged_word - old_word with the store lanes replaced
//   byte_en     - lanes written by the store
//   load_word   - selected byte/halfword/word, sign- or zero-extended
//   misalign    - halfword on an odd address or word not on a 4-byte boundary
module dmem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] merged_word,
  output logic [3:0]  byte_en,
  output logic [31:0] load_word,
  output logic        misalign
);

  logic [31:0] lane_data;
  logic [31:0] shifted;

  // Bring the addressed byte/halfword down to bit 0 for extraction.
  assign shifted = old_word >> {addr_lo, 3'b000};

  always_comb begin
    byte_en   = 4'b0000;
    lane_data = 32'h0;
    load_word = 32'h0;
    misalign  = 1'b0;
    case (funct3)
      F3_B: begin
        byte_en   = 4'b0001 << addr_lo;
        lane_data = {4{store_data[7:0]}};
        load_word = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        lane_data = {4{store_data[7:0]}};
        load_word = {24'h0, shifted[7:0]};
      end
      F3_H: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{store_data[15:0]}};
        load_word = {{16{shifted[15]}}, shifted[15:0]};
        misalign  = addr_lo[0];
      end
      F3_HU: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{store_data[15:0]}};
        load_word = {16'h0, shifted[15:0]};
        misalign  = addr_lo[0];
      end
      F3_W: begin
        byte_en   = 4'b1111;
        lane_data = store_data;
        load_word = old_word;
        misalign  = |addr_lo;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_word[gi*8 +: 8] = byte_en[gi] ? lane_data[gi*8 +: 8] : old_word[gi*8 +: 8];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's MEM stage.
// Accepts one load/store at a time, holds the core with mem_stall for
// WAIT_CYCLES+1 cycles, then pulses rvalid with extended load data or an
// access error. Stores commit in the response cycle only when error-free.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   memread, memwrite  - load / store strobes (both high = erroneous store)
//   addr, wdata, funct3- byte address, store data, access size/sign
//   mem_stall          - pipeline freeze while the request is busy
//   rvalid             - one-cycle completion pulse (loads and stores)
//   rdata              - extended load data, valid with rvalid on a load
//   access_err         - error flag, valid with rvalid
module dmem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        mem_stall,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        access_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [2:0]  funct3_reg;
  logic        is_store_reg, dual_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic        wr_en_reg;
  logic [31:0] wr_word_reg;
  logic [AW-1:0] wr_idx_reg;

  logic [31:0] mem_array [DEPTH_WORDS];

  logic        req, idle, accept, to_resp;
  logic [31:0] cur_addr, cur_wdata, offset, old_word;
  logic [2:0]  cur_funct3;
  logic        cur_store, cur_dual;
  logic        out_of_range, illegal, misalign, err;
  logic [AW-1:0] cur_idx;
  logic [31:0] merged_word, load_word;
  logic [3:0]  byte_en;

  assign req    = memread | memwrite;
  assign idle   = (state_reg == IDLE);
  assign accept = idle & req;

  // With zero wait states the response is formed straight from the live
  // inputs in the accept cycle; otherwise from the latched request.
  assign cur_addr   = idle ? addr     : addr_reg;
  assign cur_wdata  = idle ? wdata    : wdata_reg;
  assign cur_funct3 = idle ? funct3   : funct3_reg;
  assign cur_store  = idle ? memwrite : is_store_reg;
  assign cur_dual   = idle ? (memread & memwrite) : dual_reg;

  // Unsigned subtraction: addresses below the base wrap high and fail the range check.
  assign offset       = cur_addr - ADDR_BASE;
  assign out_of_range = (offset >= SPAN);
  assign cur_idx      = offset[AW+1:2];
  assign illegal      = f3_illegal(cur_funct3, cur_store);
  assign err          = misalign | out_of_range | illegal | cur_dual;
  assign old_word     = mem_array[cur_idx];

  assign to_resp = (accept && WAIT_CYCLES == 0) || (state_reg == WAIT && cnt_reg == 4'd0);

  dmem_lane_fmt u_lane_fmt (
    .addr_lo     (cur_addr[1:0]),
    .funct3      (cur_funct3),
    .old_word    (old_word),
    .store_data  (cur_wdata),
    .merged_word (merged_word),
    .byte_en     (byte_en),
    .load_word   (load_word),
    .misalign    (misalign)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req) state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (cnt_reg == 4'd0) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_stall = accept | (state_reg == WAIT);
    rvalid    = (state_reg == RESP);
  end

  // Request latches, wait counter and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= 4'd0;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      funct3_reg   <= 3'b000;
      is_store_reg <= 1'b0;
      dual_reg     <= 1'b0;
      rdata_reg    <= 32'h0;
      err_reg      <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_word_reg  <= 32'h0;
      wr_idx_reg   <= '0;
    end else begin
      if (accept) begin
        addr_reg     <= addr;
        wdata_reg    <= wdata;
        funct3_reg   <= funct3;
        is_store_reg <= memwrite;
        dual_reg     <= memread & memwrite;
        cnt_reg      <= CNT_LOAD;
      end else if (state_reg == WAIT && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end

      if (to_resp) begin
        rdata_reg   <= (err || cur_store) ? 32'h0 : load_word;
        err_reg     <= err;
        wr_en_reg   <= cur_store & ~err;
        wr_word_reg <= merged_word;
        wr_idx_reg  <= cur_idx;
      end else if (state_reg == RESP) begin
        // Response fields are only held for the single RESP cycle.
        rdata_reg <= 32'h0;
        err_reg   <= 1'b0;
        wr_en_reg <= 1'b0;
      end
    end
  end

  // Storage: no reset; reset asynchronously leaves RESP so an aborted store never commits.
  always_ff @(posedge clk) begin
    if (state_reg == RESP && wr_en_reg)
      mem_array[wr_idx_reg] <= wr_word_reg;
  end

  assign rdata      = rdata_reg;
  assign access_err = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance a uses two wait states,
// instance b uses none.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        a_rst, a_memread, a_memwrite, a_stall, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [2:0]  a_funct3;
  logic        b_rst, b_memread, b_memwrite, b_stall, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [2:0]  b_funct3;

  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst(a_rst), .memread(a_memread), .memwrite(a_memwrite),
    .addr(a_addr), .wdata(a_wdata), .funct3(a_funct3),
    .mem_stall(a_stall), .rvalid(a_rvalid), .rdata(a_rdata), .access_err(a_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(b_rst), .memread(b_memread), .memwrite(b_memwrite),
    .addr(b_addr), .wdata(b_wdata), .funct3(b_funct3),
    .mem_stall(b_stall), .rvalid(b_rvalid), .rdata(b_rdata), .access_err(b_err)
  );

  // Issue one request (called at posedge+1 in an idle cycle); returns at
  // posedge+1 of the idle cycle following the response.
  task automatic xact(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f3,
                      output logic [31:0] rdat, output logic err, output int stalls,
                      output int lat, output int vcyc);
    bit seen;
    seen = 1'b0; stalls = 0; lat = -1; vcyc = -1; rdat = 32'h0; err = 1'b0;
    if (sel) begin b_memread = rd; b_memwrite = wr; b_addr = a; b_wdata = d; b_funct3 = f3; end
    else     begin a_memread = rd; a_memwrite = wr; a_addr = a; a_wdata = d; a_funct3 = f3; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel ? b_stall : a_stall) stalls++;
      if (sel ? b_rvalid : a_rvalid) begin
        rdat = sel ? b_rdata : a_rdata;
        err  = sel ? b_err : a_err;
        lat = i; vcyc = cyc; seen = 1'b1;
        break;
      end
    end
    a_memread = 1'b0; a_memwrite = 1'b0; b_memread = 1'b0; b_memwrite = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_%s: no rvalid within 20 cycles, required a response", sel ? "b" : "a");
    end
    $display("xact dut=%s rd=%0b wr=%0b addr=%08h wdata=%08h f3=%03b -> rdata=%08h err=%0b stalls=%0d lat=%0d",
             sel ? "b" : "a", rd, wr, a, d, f3, rdat, err, stalls, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_memread = 0; a_memwrite = 0; a_addr = 0; a_wdata = 0; a_funct3 = 0;
    b_memread = 0; b_memwrite = 0; b_addr = 0; b_wdata = 0; b_funct3 = 0;
    repeat (3) @(negedge clk);
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", a_rvalid); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", a_stall); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", a_err); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %08h want 0", a_rdata); end
    checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_b_rvalid: got %b want 0", b_rvalid); end
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] r; logic e; int s, l, v;
    xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, r, e, s, l, v);
    checks++; if (s != 3) begin errors++; $display("FAIL sw_stall: got %0d want 3", s); end
    checks++; if (l != 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", l); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL sw_err: got %b want 0", e); end
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_one_cycle: got %b want 0", a_rvalid); end
    @(posedge clk); #1;
    xact(0, 1, 0, 32'h10, 32'h0, 3'b010, r, e, s, l, v);
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %08h want deadbeef", r); end
    checks++; if (s != 3) begin errors++; $display("FAIL lw_stall: got %0d want 3", s); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", e); end
  endtask

  task automatic test_subword();
    logic [31:0] r; logic e; int s, l, v;
    xact(0, 0, 1, 32'h11, 32'h000000A5, 3'b000, r, e, s, l, v);
    xact(0, 1, 0, 32'h10, 32'h0, 3'b010, r, e, s, l, v);
    checks++; if (r !== 32'hDEADA5EF) begin errors++; $display("FAIL sb_merge: got %08h want deada5ef", r); end
    xact(0, 1, 0, 32'h11, 32'h0, 3'b000, r, e, s, l, v);
    checks++; if (r !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb: got %08h want ffffffa5", r); end
    xact(0, 1, 0, 32'h11, 32'h0, 3'b100, r, e, s, l, v);
    checks++; if (r !== 32'h000000A5) begin errors++; $display("FAIL lbu: got %08h want 000000a5", r); end
    xact(0, 0, 1, 32'h20, 32'h00000000, 3'b010, r, e, s, l, v);
    xact(0, 0, 1, 32'h22, 32'h00008001, 3'b001, r, e, s, l, v);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL sh_err: got %b want 0", e); end
    xact(0, 1, 0, 32'h22, 32'h0, 3'b001, r, e, s, l, v);
    checks++; if (r !== 32'hFFFF8001) begin errors++; $display("FAIL lh: got %08h want ffff8001", r); end
    xact(0, 1, 0, 32'h22, 32'h0, 3'b101, r, e, s, l, v);
    checks++; if (r !== 32'h00008001) begin errors++; $display("FAIL lhu: got %08h want 00008001", r); end
    xact(0, 1, 0, 32'h20, 32'h0, 3'b010, r, e, s, l, v);
    checks++; if (r !== 32'h80010000) begin errors++; $display("FAIL sh_merge: got %08h want 80010000", r); end
  endtask

  task automatic test_errors();
    // rd, wr, addr, wdata, funct3: every entry must be rejected
    logic [31:0] t_addr [6] = '{32'h13, 32'h21, 32'h1000, 32'h10, 32'h10, 32'h10};
    logic [31:0] t_data [6] = '{32'h0, 32'hFFFF, 32'h0, 32'h11111111, 32'h0, 32'h22};
    logic [2:0]  t_f3   [6] = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b011, 3'b100};
    bit          t_rd   [6] = '{1, 0, 1, 1, 1, 0};
    bit          t_wr   [6] = '{0, 1, 0, 1, 0, 1};
    logic [31:0] r; logic e; int s, l, v;
    for (int k = 0; k < 6; k++) begin
      xact(0, t_rd[k], t_wr[k], t_addr[k], t_data[k], t_f3[k], r, e, s, l, v);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_flag_%0d: got %b want 1", k, e); end
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL err_rdata_%0d: got %08h want 0", k, r); end
    end
    xact(0, 1, 0, 32'h20, 32'h0, 3'b010, r, e, s, l, v);
    checks++; if (r !== 32'h80010000) begin errors++; $display("FAIL err_no_write_20: got %08h want 80010000", r); end
    xact(0, 1, 0, 32'h10, 32'h0, 3'b010, r, e, s, l, v);
    checks++; if (r !== 32'hDEADA5EF) begin errors++; $display("FAIL err_no_write_10: got %08h want deada5ef", r); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r; logic e; int s, l, v;
    xact(0, 0, 1, 32'h30, 32'hAAAA5555, 3'b010, r, e, s, l, v);
    a_memwrite = 1'b1; a_addr = 32'h30; a_wdata = 32'h12345678; a_funct3 = 3'b010;
    @(posedge clk); #1;              // accepted; now in WAIT
    a_rst = 1'b1; a_memwrite = 1'b0;
    $display("xact dut=a reset asserted during WAIT of sw 00000030");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL abort_rvalid_%0d: got %b want 0", k, a_rvalid); end
    end
    @(posedge clk); #1;
    a_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (a_rvalid !== 1'b0 || a_stall !== 1'b0) begin
        errors++; $display("FAIL abort_idle_%0d: got rvalid=%b stall=%b want 0/0", k, a_rvalid, a_stall);
      end
    end
    @(posedge clk); #1;
    xact(0, 1, 0, 32'h30, 32'h0, 3'b010, r, e, s, l, v);
    checks++; if (r !== 32'hAAAA5555) begin errors++; $display("FAIL abort_no_commit: got %08h want aaaa5555", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; logic e; int s1, s2, l, v1, v2;
    xact(1, 0, 1, 32'h0, 32'h11223344, 3'b010, r1, e, s1, l, v1);
    checks++; if (s1 != 1) begin errors++; $display("FAIL b_sw_stall: got %0d want 1", s1); end
    xact(1, 0, 1, 32'h4, 32'h55667788, 3'b010, r1, e, s1, l, v1);
    xact(1, 1, 0, 32'h0, 32'h0, 3'b010, r1, e, s1, l, v1);
    xact(1, 1, 0, 32'h4, 32'h0, 3'b010, r2, e, s2, l, v2);
    checks++; if (r1 !== 32'h11223344) begin errors++; $display("FAIL b2b_data0: got %08h want 11223344", r1); end
    checks++; if (r2 !== 32'h55667788) begin errors++; $display("FAIL b2b_data1: got %08h want 55667788", r2); end
    checks++; if (s1 != 1 || s2 != 1) begin errors++; $display("FAIL b2b_stall: got %0d/%0d want 1/1", s1, s2); end
    checks++; if (v2 - v1 != 2) begin errors++; $display("FAIL b2b_spacing: got %0d want 2", v2 - v1); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the load/store requests the RISC_V core issues from its MEM stage: address, write data, read/write strobes and funct3.
- Holds a word-organised storage array.
- Inserts a configurable number of wait states and raises a stall back to the core while a request is outstanding.
- Returns sign- or zero-extended load data, merges byte and halfword stores, and flags misaligned, out-of-range or illegal accesses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in storage; power of two, 16 to 65536.
- ADDR_BASE, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_CYCLES, 2, extra cycles between acceptance and response; legal range 0 to 15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- memread  in  1  load request from the core (memread_MEM).
- memwrite  in  1  store request from the core (memwrite_MEM).
- addr  in  32  byte address (ALU result in the MEM stage).
- wdata  in  32  store data; the LSB-aligned byte or halfword is used for SB/SH.
- funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_stall  out  1  freezes the core pipeline while the request is busy.
- rvalid  out  1  one-cycle completion pulse; stores pulse as well.
- rdata  out  32  extended load data; meaningful only when rvalid=1 on a load.
- access_err  out  1  high together with rvalid for an erroneous access.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; rvalid, rdata and access_err are 0; the wait counter is 0.
  - Storage contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - A request is req = memread|memwrite.
  - On req, latch addr, wdata, funct3 and the store/load type (is_store=memwrite).
  - Go to WAIT with counter=WAIT_CYCLES-1 when WAIT_CYCLES>0; otherwise go to RESP.
  - memread and memwrite both high: treated as a store, with access_err raised at response time.
- WAIT: decrement the counter each cycle; leave for RESP when the counter reaches 0.
- RESP:
  - rvalid=1 for exactly one cycle and drives the response; then return to IDLE unconditionally.
  - Inputs are ignored in RESP, because the core is still presenting the same held request.
- mem_stall (combinational):
  - Formula: (state==IDLE & req) | state==WAIT.
  - It is low in RESP, so the core advances on the response edge.
  - Latency: rvalid rises WAIT_CYCLES+1 cycles after the acceptance cycle, and the total stall is WAIT_CYCLES+1 cycles.
- Error checks, evaluated on the latched request:
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0;
  - out of range: (addr-ADDR_BASE)>=DEPTH_WORDS*4, using unsigned 32-bit subtraction so wrap-below-base counts as out of range;
  - illegal: funct3 in {011,110,111}, or a store with funct3 of 100 or 101;
  - the dual read+write strobe described under IDLE.
- On any error: access_err=1, rdata=0, storage unmodified.
- Loads: index = (addr-ADDR_BASE)[log2(DEPTH_WORDS)+1:2].
  - The byte is selected by addr[1:0] and the halfword by addr[1].
  - B/H are sign-extended; BU/HU are zero-extended; W passes through.
  - rdata is registered and valid in the RESP cycle.
- Stores: the byte-lane merge is written in the RESP cycle, with write enable only when there is no error.
  - SB writes lane addr[1:0].
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
- Reset during WAIT or RESP: abort to IDLE; no store commits; rvalid does not pulse.
- Back-to-back requests: the next request is accepted in the IDLE cycle following RESP, with no extra bubble beyond that one cycle.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state typedef: IDLE, WAIT, RESP.
- One combinational sub-module, dmem_lane_fmt:
  - inputs: addr[1:0], funct3, old word, store data;
  - outputs: merged store word, 4-bit byte-enable, extended load word, misalign flag.
- The top level holds the FSM, counter, request latches, range check and storage array.

Test Plan:
- WAIT_CYCLES=2, SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> mem_stall high 3 cycles per access; rvalid one cycle after the stall drops; rdata=0xDEADBEEF; access_err=0.
- After the SW above: SB addr=0x11 wdata=0x000000A5, then LW 0x10 -> 0xDEADA5EF. LB 0x11 -> 0xFFFFFFA5. LBU 0x11 -> 0x000000A5.
- SH addr=0x22 wdata=0x00008001, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> upper half 0x8001.
- LW 0x13, SH 0x21 and LW DEPTH_WORDS*4 -> rvalid with access_err=1 and rdata=0; a follow-up read shows the target word unchanged.
- Assert rst during WAIT of SW addr=0x30 wdata=0x12345678 -> no rvalid; state returns to IDLE; a later LW 0x30 returns the prior contents.
- WAIT_CYCLES=0, back-to-back LW 0x0 then LW 0x4 -> each access stalls 1 cycle; the rvalid pulses are 2 cycles apart.
